// File: rtl/pwl_pkg.sv
// Shared types for the piecewise-linear activation unit: table entry, reset entry, saturation.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pwl_pkg;

    localparam int PWL_DATA_W  = 16;
    localparam int PWL_SHIFT_W = 4;

    // One segment of the table: y = sat(((x - bp) >>> shift) + bias), or 0 when zero is set.
    typedef struct packed {
        logic signed [PWL_DATA_W-1:0]  bp;
        logic        [PWL_SHIFT_W-1:0] shift;
        logic signed [PWL_DATA_W-1:0]  bias;
        logic                          zero;
    } pwl_entry_t;

    // Reset entry matches every x and forces 0, so an unloaded unit outputs 0.
    localparam pwl_entry_t PWL_ENTRY_RST = '{
        bp:    {1'b1, {(PWL_DATA_W-1){1'b0}}},
        shift: '0,
        bias:  '0,
        zero:  1'b1
    };

    // Clamp a DATA_W+2 bit signed sum into the DATA_W signed range.
    function automatic logic signed [PWL_DATA_W-1:0] pwl_sat(input logic signed [PWL_DATA_W+1:0] r);
        logic signed [PWL_DATA_W+1:0] max_v;
        logic signed [PWL_DATA_W+1:0] min_v;
        max_v = {3'b000, {(PWL_DATA_W-1){1'b1}}};
        min_v = {3'b111, {(PWL_DATA_W-1){1'b0}}};
        if (r > max_v) begin
            return {1'b0, {(PWL_DATA_W-1){1'b1}}};
        end else if (r < min_v) begin
            return {1'b1, {(PWL_DATA_W-1){1'b0}}};
        end
        return r[PWL_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pwl_act_pipe_seg_sel.sv
// Segment select: SEG_N-way signed compare of x against every breakpoint, highest matching index wins.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module pwl_seg_sel
    import pwl_pkg::*;
#(
    parameter int DATA_W = PWL_DATA_W,
    parameter int SEG_N  = 16,
    parameter int IDX_W  = $clog2(SEG_N)
) (
    input  logic signed [DATA_W-1:0]            x_i,
    input  logic        [SEG_N-1:0][DATA_W-1:0] bp_i,
    output logic        [IDX_W-1:0]             seg_o
);

    // Ascending scan so a later (higher) match overrides; no match falls back to segment 0.
    always_comb begin
        seg_o = '0;
        for (int i = 0; i < SEG_N; i++) begin
            if (x_i >= $signed(bp_i[i])) begin
                seg_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pwl_act_pipe.sv
// Programmable piecewise-linear activation: select segment, subtract/shift, add bias and saturate.
// Latency: 3 cycles accept-to-out_valid, 1 sample/cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready follows out_ready combinationally.
// DATA_W and SHIFT_W must equal the package widths since the table entry type comes from pwl_pkg.
module pwl_act_pipe
    import pwl_pkg::*;
#(
    parameter int DATA_W  = PWL_DATA_W,
    parameter int SEG_N   = 16,
    parameter int SHIFT_W = PWL_SHIFT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_y,
    input  logic                       cfg_we,
    input  logic [$clog2(SEG_N)-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]          cfg_bp,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic [DATA_W-1:0]          cfg_bias,
    input  logic                       cfg_zero
);

    localparam int IDX_W = $clog2(SEG_N);

    pwl_entry_t                    tbl_q [SEG_N];
    logic [SEG_N-1:0][DATA_W-1:0]  bp_vec;
    logic [IDX_W-1:0]              sel;
    logic                          en;

    logic                          v1_q, v2_q, v3_q;
    logic signed [DATA_W-1:0]      x1_q;
    pwl_entry_t                    e1_q;
    logic signed [DATA_W:0]        d2;
    logic signed [DATA_W:0]        s2_d, s2_q;
    logic signed [DATA_W-1:0]      bias2_q;
    logic                          zero2_q;
    logic signed [DATA_W+1:0]      r3;
    logic signed [DATA_W-1:0]      y3_d, y3_q;

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign out_y     = y3_q;

    // Flatten breakpoints for the comparator bank.
    always_comb begin
        bp_vec = '0;
        for (int i = 0; i < SEG_N; i++) begin
            bp_vec[i] = tbl_q[i].bp;
        end
    end

    pwl_seg_sel #(
        .DATA_W (DATA_W),
        .SEG_N  (SEG_N),
        .IDX_W  (IDX_W)
    ) u_seg_sel (
        .x_i   ($signed(in_x)),
        .bp_i  (bp_vec),
        .seg_o (sel)
    );

    // Table write; S1 samples the old contents on the same edge, so in-flight samples are unaffected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEG_N; i++) begin
                tbl_q[i] <= PWL_ENTRY_RST;
            end
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= '{bp: cfg_bp, shift: cfg_shift, bias: cfg_bias, zero: cfg_zero};
        end
    end

    // S2 and S3 datapath: widened subtract, arithmetic shift, widened add, clamp.
    always_comb begin
        d2   = {x1_q[DATA_W-1], x1_q} - {e1_q.bp[DATA_W-1], e1_q.bp};
        s2_d = d2 >>> e1_q.shift;
        r3   = {s2_q[DATA_W], s2_q} + {{2{bias2_q[DATA_W-1]}}, bias2_q};
        y3_d = zero2_q ? '0 : pwl_sat(r3);
    end

    // Stage valid bits shift together on the global advance; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Stage data registers; holding on !en keeps out_y stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q    <= '0;
            e1_q    <= PWL_ENTRY_RST;
            s2_q    <= '0;
            bias2_q <= '0;
            zero2_q <= 1'b1;
            y3_q    <= '0;
        end else if (en) begin
            x1_q    <= $signed(in_x);
            e1_q    <= tbl_q[sel];
            s2_q    <= s2_d;
            bias2_q <= e1_q.bias;
            zero2_q <= e1_q.zero;
            y3_q    <= y3_d;
        end
    end

endmodule
